// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the CPU MEM stage: accepts one load/store,
// waits LATENCY cycles, commits byte-enabled writes and returns a registered response.
module data_mem_responder #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ENTRY_COUNT = 32,
  parameter int unsigned LATENCY     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [31:0]             req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    stall
);

  localparam int unsigned NumLanes = DATA_WIDTH / 8;
  localparam int unsigned IdxW     = (ENTRY_COUNT > 1) ? $clog2(ENTRY_COUNT) : 1;
  localparam int unsigned CntW     = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  we_q;
  logic [31:0]           addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NumLanes-1:0]   be_q;
  logic [DATA_WIDTH-1:0] mem_q [ENTRY_COUNT];
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;

  logic                  accept;
  logic                  commit;
  logic [29:0]           word_idx;
  logic [IdxW-1:0]       mem_idx;
  logic                  addr_err;

  // Full decode of the upper address bits: no aliasing onto low indices.
  assign word_idx = addr_q[31:2];
  assign mem_idx  = word_idx[IdxW-1:0];
  assign addr_err = (addr_q[1:0] != 2'b00) || (word_idx >= 30'(ENTRY_COUNT));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          accept  = 1'b1;
          cnt_d   = CntW'(LATENCY - 1);
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign req_ready = (state_q == StIdle);
  assign stall     = ((state_q == StIdle) && req_valid) || (state_q == StBusy);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= commit;
      if (commit) begin
        rsp_err_q   <= addr_err;
        rsp_rdata_q <= (!we_q && !addr_err) ? mem_q[mem_idx] : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(ENTRY_COUNT); i++) begin
        mem_q[i] <= '0;
      end
    end else if (commit && we_q && !addr_err) begin
      for (int l = 0; l < int'(NumLanes); l++) begin
        if (be_q[l]) begin
          mem_q[mem_idx][8*l +: 8] <= wdata_q[8*l +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder; three instances cover LATENCY = 2, 1 and 4.
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_be    [3];
  logic        rsp_valid [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];
  logic        stall     [3];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_responder #(
      .DATA_WIDTH (32),
      .ENTRY_COUNT(32),
      .LATENCY    ((g == 0) ? 2 : (g == 1) ? 1 : 4)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_we   (req_we[g]),
      .req_addr (req_addr[g]),
      .req_wdata(req_wdata[g]),
      .req_be   (req_be[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_err  (rsp_err[g]),
      .stall    (stall[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and returns in the RESP cycle with the captured response.
  task automatic xact(input int k, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      output logic [31:0] rdata, output logic err,
                      output int stall_cnt, output int cyc);
    int n;
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_be[k]    = be;
    n = 0;
    while (!req_ready[k] && n < 100) begin
      tick();
      n++;
    end
    stall_cnt = 0;
    cyc       = 0;
    while (!rsp_valid[k] && cyc < 100) begin
      if (stall[k]) stall_cnt++;
      tick();
      cyc++;
      if (cyc == 1) req_valid[k] = 1'b0;
    end
    req_valid[k] = 1'b0;
    rdata = rsp_rdata[k];
    err   = rsp_err[k];
    checks++;
    if (cyc >= 100) begin
      errors++;
      $display("FAIL xact_timeout inst=%0d addr=%h got no rsp_valid within %0d cycles, need one",
               k, addr, cyc);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic        er;
    int          sc, cy;
    rst = 1'b0;
    #3;
    checks++;
    if (req_ready[0] !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b need 1", req_ready[0]);
    end
    checks++;
    if (stall[0] !== 1'b0) begin
      errors++; $display("FAIL reset_stall got %b need 0", stall[0]);
    end
    checks++;
    if (rsp_valid[0] !== 1'b0 || rsp_rdata[0] !== 32'h0 || rsp_err[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp got valid=%b rdata=%h err=%b need 0/00000000/0",
               rsp_valid[0], rsp_rdata[0], rsp_err[0]);
    end
    req_valid[0] = 1'b1;
    #1;
    checks++;
    if (stall[0] !== 1'b1) begin
      errors++; $display("FAIL reset_stall_follows_valid got %b need 1", stall[0]);
    end
    req_valid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    xact(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, sc, cy);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      errors++; $display("FAIL reset_load_0 got %h err=%b need 00000000 err=0", rd, er);
    end
    xact(0, 1'b0, 32'h7C, 32'h0, 4'h0, rd, er, sc, cy);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      errors++; $display("FAIL reset_load_7c got %h err=%b need 00000000 err=0", rd, er);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd;
    logic        er;
    int          sc, cy;
    xact(0, 1'b1, 32'h8, 32'hDEADBEEF, 4'hF, rd, er, sc, cy);
    checks++;
    if (sc !== 3) begin
      errors++; $display("FAIL store_stall_cycles got %0d need 3", sc);
    end
    checks++;
    if (cy !== 3) begin
      errors++; $display("FAIL store_rsp_latency got %0d edges need 3", cy);
    end
    checks++;
    if (er !== 1'b0 || rd !== 32'h0) begin
      errors++; $display("FAIL store_rsp got rdata=%h err=%b need 00000000 err=0", rd, er);
    end
    checks++;
    if (stall[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL resp_cycle_flags got stall=%b ready=%b need 0/0", stall[0], req_ready[0]);
    end
    tick();
    checks++;
    if (rsp_valid[0] !== 1'b0) begin
      errors++; $display("FAIL rsp_valid_one_cycle got %b need 0", rsp_valid[0]);
    end
    xact(0, 1'b0, 32'h8, 32'h0, 4'h0, rd, er, sc, cy);
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      errors++; $display("FAIL load_after_store got %h err=%b need deadbeef err=0", rd, er);
    end
  endtask

  task automatic test_byte_enables();
    logic [31:0] rd;
    logic        er;
    int          sc, cy;
    xact(0, 1'b1, 32'h8, 32'h11223344, 4'b0101, rd, er, sc, cy);
    xact(0, 1'b0, 32'h8, 32'h0, 4'h0, rd, er, sc, cy);
    checks++;
    if (rd !== 32'hDE22BE44) begin
      errors++; $display("FAIL byte_enable_merge got %h need de22be44", rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic        er;
    logic [31:0] exp;
    int          sc, cy;
    xact(0, 1'b0, 32'h82, 32'h0, 4'h0, rd, er, sc, cy);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL misaligned_load got rdata=%h err=%b need 00000000 err=1", rd, er);
    end
    xact(0, 1'b1, 32'h80, 32'hFFFFFFFF, 4'hF, rd, er, sc, cy);
    checks++;
    if (er !== 1'b1) begin
      errors++; $display("FAIL out_of_range_store got err=%b need 1", er);
    end
    for (int w = 0; w < 32; w++) begin
      exp = (w == 2) ? 32'hDE22BE44 : 32'h0;
      xact(0, 1'b0, 32'(w * 4), 32'h0, 4'h0, rd, er, sc, cy);
      checks++;
      if (rd !== exp || er !== 1'b0) begin
        errors++;
        $display("FAIL scan_word_%0d got %h err=%b need %h err=0", w, rd, er, exp);
      end
    end
  endtask

  task automatic test_back_to_back(input int k);
    int          lat, n;
    logic [31:0] exp;
    lat = lat_of(k);
    exp = (k == 0) ? 32'hDE22BE44 : 32'h0;
    req_valid[k] = 1'b1;
    req_we[k]    = 1'b0;
    req_addr[k]  = 32'h8;
    req_be[k]    = 4'h0;
    n = 0;
    while (!req_ready[k] && n < 100) begin
      tick();
      n++;
    end
    tick();
    n = 0;
    while (!req_ready[k] && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (n !== lat + 1) begin
      errors++;
      $display("FAIL b2b_notready_cycles lat=%0d got %0d need %0d", lat, n, lat + 1);
    end
    checks++;
    if (stall[k] !== 1'b1) begin
      errors++; $display("FAIL b2b_stall_idle lat=%0d got %b need 1", lat, stall[k]);
    end
    tick();
    req_valid[k] = 1'b0;
    checks++;
    if (req_ready[k] !== 1'b0 || stall[k] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_accept lat=%0d got ready=%b stall=%b need 0/1",
               lat, req_ready[k], stall[k]);
    end
    n = 0;
    while (!rsp_valid[k] && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (n !== lat || rsp_rdata[k] !== exp) begin
      errors++;
      $display("FAIL b2b_second_rsp lat=%0d got %0d cycles rdata=%h need %0d cycles rdata=%h",
               lat, n, rsp_rdata[k], lat, exp);
    end
    tick();
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] rd;
    logic        er;
    int          sc, cy;
    bit          seen;
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 32'h10;
    req_wdata[0] = 32'hA5A5A5A5;
    req_be[0]    = 4'hF;
    cy = 0;
    while (!req_ready[0] && cy < 100) begin
      tick();
      cy++;
    end
    tick();
    req_valid[0] = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1 || stall[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_busy_reset got valid=%b ready=%b stall=%b need 0/1/0",
               rsp_valid[0], req_ready[0], stall[0]);
    end
    #2 rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid[0]) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL dropped_request_rsp got rsp_valid=1 need none");
    end
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, sc, cy);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL dropped_store_load got %h need 00000000", rd);
    end
    xact(0, 1'b1, 32'h14, 32'h12345678, 4'hF, rd, er, sc, cy);
    xact(0, 1'b0, 32'h14, 32'h0, 4'h0, rd, er, sc, cy);
    rst = 1'b0;
    #1;
    checks++;
    if (rsp_valid[0] !== 1'b0 || rsp_rdata[0] !== 32'h0) begin
      errors++;
      $display("FAIL resp_reset got valid=%b rdata=%h need 0/00000000",
               rsp_valid[0], rsp_rdata[0]);
    end
    #1 rst = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0;
      req_we[k]    = 1'b0;
      req_addr[k]  = 32'h0;
      req_wdata[k] = 32'h0;
      req_be[k]    = 4'h0;
    end
    test_reset();
    test_store_load();
    test_byte_enables();
    test_errors();
    test_back_to_back(0);
    test_back_to_back(1);
    test_back_to_back(2);
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
